// File: rtl/bus_memory_ctrl.sv
// Single-port main memory with MAR for the tiny16 bus: boot-image load sequencer,
// sticky out-of-range fault, gated read drive. Optional MAR auto-increment: MEM_AUTOINC_EN.
module bus_memory_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int MEM_SIZE = 256,
    parameter int INIT_LEN = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              addr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic              in_en,
    input  logic [DATA_W-1:0] in,
    input  logic              out_en,
    output logic [DATA_W-1:0] out,
    output logic              busy,
    output logic              fault
);

    localparam int                IDX_W  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_W:0]   SIZE_X = (ADDR_W+1)'(MEM_SIZE);
    localparam logic [ADDR_W:0]   INIT_X = (ADDR_W+1)'(INIT_LEN);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(MEM_SIZE - 1);

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] load_cnt;
    logic [ADDR_W-1:0] mar;
    logic              in_range;
    logic              access;

    logic [DATA_W-1:0] mem [0:MEM_SIZE-1];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Boot words are defined at 16 bits and resized to the data width.
    function automatic logic [DATA_W-1:0] boot_word(input logic [ADDR_W-1:0] idx);
        logic [15:0] w;
        w = 16'h0000;
        if ({1'b0, idx} < INIT_X) begin
            case (idx)
                ADDR_W'(0): w = 16'h1500;
                ADDR_W'(1): w = 16'h1701;
                ADDR_W'(2): w = 16'h3430;
                ADDR_W'(3): w = 16'h0220;
                ADDR_W'(4): w = 16'hC002;
                default:    w = 16'h0000;
            endcase
        end
        return DATA_W'(w);
    endfunction

    assign in_range = ({1'b0, mar} < SIZE_X);
    assign access   = in_en || out_en;
    assign busy     = (state == ST_LOAD);

    // The loader and the bus share the single write port; loader owns it while busy.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = load_cnt[IDX_W-1:0];
        mem_wdata = boot_word(load_cnt);
        if (!rst) begin
            if (state == ST_LOAD) begin
                mem_we = 1'b1;
            end else if (in_en && in_range) begin
                mem_we    = 1'b1;
                mem_waddr = mar[IDX_W-1:0];
                mem_wdata = in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_LOAD;
            load_cnt <= '0;
            mar      <= '0;
            fault    <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    load_cnt <= load_cnt + ADDR_W'(1);
                    if (load_cnt == LAST) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    if (addr_en) begin
                        mar <= addr;
`ifdef MEM_AUTOINC_EN
                    end else if (access && in_range) begin
                        mar <= (mar == LAST) ? '0 : mar + ADDR_W'(1);
`endif
                    end
                    if (access && !in_range) begin
                        fault <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Read is combinational off the current MAR; a write lands on out one cycle later.
    assign out = (state == ST_RUN && out_en && in_range) ? mem[mar[IDX_W-1:0]] : '0;

endmodule

// File: tb/tb_bus_memory_ctrl.sv
// Directed self-checking bench for bus_memory_ctrl (default 16/16/256/5 configuration).
module tb_bus_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        addr_en;
    logic [15:0] addr;
    logic        in_en;
    logic [15:0] din;
    logic        out_en;
    logic [15:0] dout;
    logic        busy;
    logic        fault;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_memory_ctrl #(
        .DATA_W(16), .ADDR_W(16), .MEM_SIZE(256), .INIT_LEN(5)
    ) dut (
        .clk(clk), .rst(rst), .addr_en(addr_en), .addr(addr),
        .in_en(in_en), .in(din), .out_en(out_en), .out(dout),
        .busy(busy), .fault(fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        addr_en = 1'b1;
        addr    = a;
        tick();
        addr_en = 1'b0;
        out_en  = 1'b1;
        #1;
        d       = dout;
        out_en  = 1'b0;
    endtask

    task automatic wait_load(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            tick();
            cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; addr_en = 1'b0; addr = '0; in_en = 1'b0; din = '0; out_en = 1'b0;
        tick(); tick();
        out_en = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", busy); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", fault); end
        n_cmp++; if (dout !== 16'h0000) begin n_bad++; $display("FAIL reset_out: got %h want 0000", dout); end
        out_en = 1'b0;
    endtask

    task automatic test_load();
        int cnt;
        int bad_out;
        logic [15:0] d;
        logic [15:0] a_tab [7];
        logic [15:0] e_tab [7];
        a_tab = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd255};
        e_tab = '{16'h1500, 16'h1701, 16'h3430, 16'h0220, 16'hC002, 16'h0000, 16'h0000};
        // bus strobes held active for the whole load must have no effect
        addr_en = 1'b1; addr = 16'd3; in_en = 1'b1; din = 16'hFFFF; out_en = 1'b1;
        rst = 1'b0;
        cnt = 0;
        bad_out = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            if (dout !== 16'h0000) bad_out++;
            tick();
            cnt++;
        end
        addr_en = 1'b0; in_en = 1'b0; out_en = 1'b0;
        n_cmp++; if (cnt != 256) begin n_bad++; $display("FAIL load_cycles: got %0d want 256", cnt); end
        n_cmp++; if (bad_out != 0) begin n_bad++; $display("FAIL load_out_zero: got %0d nonzero cycles want 0", bad_out); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL load_fault: got %b want 0", fault); end
        out_en = 1'b1;
        #1;
        n_cmp++; if (dout !== 16'h1500) begin n_bad++; $display("FAIL load_mar_zero: got %h want 1500", dout); end
        out_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rd(a_tab[i], d);
            n_cmp++;
            if (d !== e_tab[i]) begin
                n_bad++; $display("FAIL boot_read[%0d]: got %h want %h", a_tab[i], d, e_tab[i]);
            end
        end
    endtask

    task automatic test_write_read();
        logic [15:0] d;
        addr_en = 1'b1; addr = 16'd10;
        tick();
        addr_en = 1'b0; in_en = 1'b1; din = 16'hABCD; out_en = 1'b0;
        #1;
        n_cmp++; if (dout !== 16'h0000) begin n_bad++; $display("FAIL out_gated: got %h want 0000", dout); end
        tick();
        in_en = 1'b0; out_en = 1'b1;
        #1;
`ifdef MEM_AUTOINC_EN
        n_cmp++; if (dout !== 16'h0000) begin n_bad++; $display("FAIL write_visible: got %h want 0000", dout); end
`else
        n_cmp++; if (dout !== 16'hABCD) begin n_bad++; $display("FAIL write_visible: got %h want abcd", dout); end
`endif
        out_en = 1'b0;
        #1;
        n_cmp++; if (dout !== 16'h0000) begin n_bad++; $display("FAIL out_gated2: got %h want 0000", dout); end
        rd(16'd10, d);
        n_cmp++; if (d !== 16'hABCD) begin n_bad++; $display("FAIL write_read10: got %h want abcd", d); end
    endtask

    task automatic test_addr_and_write();
        logic [15:0] d;
        // mar is 10 here; the write must go to the old address
        addr_en = 1'b1; addr = 16'd20; in_en = 1'b1; din = 16'h1234;
        tick();
        addr_en = 1'b0; in_en = 1'b0; out_en = 1'b1;
        #1;
        n_cmp++; if (dout !== 16'h0000) begin n_bad++; $display("FAIL same_cycle_mem20: got %h want 0000", dout); end
        out_en = 1'b0;
        rd(16'd10, d);
        n_cmp++; if (d !== 16'h1234) begin n_bad++; $display("FAIL same_cycle_mem10: got %h want 1234", d); end
    endtask

    task automatic test_simultaneous();
        logic [15:0] d;
        addr_en = 1'b1; addr = 16'd30;
        tick();
        addr_en = 1'b0; in_en = 1'b1; din = 16'hBEEF; out_en = 1'b1;
        #1;
        n_cmp++; if (dout !== 16'h0000) begin n_bad++; $display("FAIL simul_old: got %h want 0000", dout); end
        tick();
        in_en = 1'b0;
        #1;
`ifdef MEM_AUTOINC_EN
        n_cmp++; if (dout !== 16'h0000) begin n_bad++; $display("FAIL simul_new: got %h want 0000", dout); end
`else
        n_cmp++; if (dout !== 16'hBEEF) begin n_bad++; $display("FAIL simul_new: got %h want beef", dout); end
`endif
        out_en = 1'b0;
        rd(16'd30, d);
        n_cmp++; if (d !== 16'hBEEF) begin n_bad++; $display("FAIL simul_read30: got %h want beef", d); end
    endtask

    task automatic test_autoinc();
        logic [15:0] d;
        addr_en = 1'b1; addr = 16'd254;
        tick();
        addr_en = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_en = 1'b1; din = 16'(i);
            tick();
        end
        in_en = 1'b0; out_en = 1'b1;
        #1;
`ifdef MEM_AUTOINC_EN
        n_cmp++; if (dout !== 16'h1701) begin n_bad++; $display("FAIL autoinc_mar1: got %h want 1701", dout); end
        out_en = 1'b0;
        rd(16'd254, d);
        n_cmp++; if (d !== 16'h0001) begin n_bad++; $display("FAIL autoinc_254: got %h want 0001", d); end
        rd(16'd255, d);
        n_cmp++; if (d !== 16'h0002) begin n_bad++; $display("FAIL autoinc_255: got %h want 0002", d); end
        rd(16'd0, d);
        n_cmp++; if (d !== 16'h0003) begin n_bad++; $display("FAIL autoinc_0: got %h want 0003", d); end
`else
        n_cmp++; if (dout !== 16'h0003) begin n_bad++; $display("FAIL hold_mar254: got %h want 0003", dout); end
        out_en = 1'b0;
        rd(16'd255, d);
        n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL hold_255: got %h want 0000", d); end
        rd(16'd0, d);
        n_cmp++; if (d !== 16'h1500) begin n_bad++; $display("FAIL hold_0: got %h want 1500", d); end
`endif
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL autoinc_fault: got %b want 0", fault); end
    endtask

    task automatic test_fault();
        logic [15:0] d;
        logic [15:0] exp0;
        logic [15:0] exp255;
`ifdef MEM_AUTOINC_EN
        exp0 = 16'h0003; exp255 = 16'h0002;
`else
        exp0 = 16'h1500; exp255 = 16'h0000;
`endif
        addr_en = 1'b1; addr = 16'h0100;
        tick();
        addr_en = 1'b0;
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL fault_addr_only: got %b want 0", fault); end
        in_en = 1'b1; din = 16'h5555;
        tick();
        in_en = 1'b0;
        n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL fault_set: got %b want 1", fault); end
        out_en = 1'b1;
        #1;
        n_cmp++; if (dout !== 16'h0000) begin n_bad++; $display("FAIL fault_out: got %h want 0000", dout); end
        out_en = 1'b0;
        rd(16'd0, d);
        n_cmp++; if (d !== exp0) begin n_bad++; $display("FAIL fault_mem0: got %h want %h", d, exp0); end
        rd(16'd255, d);
        n_cmp++; if (d !== exp255) begin n_bad++; $display("FAIL fault_mem255: got %h want %h", d, exp255); end
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL fault_sticky: got %b want 1", fault); end
    endtask

    task automatic test_reset_restart();
        int cnt;
        logic [15:0] d;
        rst = 1'b1;
        #2;
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL async_rst_fault: got %b want 0", fault); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL async_rst_busy: got %b want 1", busy); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        wait_load(cnt);
        n_cmp++; if (cnt != 256) begin n_bad++; $display("FAIL midload_cycles: got %0d want 256", cnt); end
        rd(16'd3, d);
        n_cmp++; if (d !== 16'h0220) begin n_bad++; $display("FAIL reload_mem3: got %h want 0220", d); end
        rd(16'd254, d);
        n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL reload_mem254: got %h want 0000", d); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_write_read();
        test_addr_and_write();
        test_simultaneous();
        test_autoinc();
        test_fault();
        test_reset_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
